// File: rtl/cpu_if.sv
// Observation bus of the cpu core: program counter, current instruction
// and the combinational ALU result.
interface cpu_if;
  logic [15:0] PC;
  logic [15:0] IR;
  logic [15:0] ALUOut;

  modport master (output PC, IR, ALUOut);
  modport slave  (input  PC, IR, ALUOut);
endinterface

// File: rtl/cpu.sv
// Single-cycle 16-bit simplified MIPS core: 16-word instruction ROM, 4-entry
// register file, combinational ALU. All state changes on the falling clock edge.
module cpu (
  input  logic  clock,
  input  logic  reset,
  cpu_if.master bus
);

  logic [15:0] pcReg;
  logic [15:0] instr;
  logic [15:0] regFile [4];
  logic [15:0] rsVal;
  logic [15:0] rtVal;
  logic [15:0] immExt;
  logic [15:0] aluResult;
  logic [15:0] nextPc;
  logic [3:0]  opcode;
  logic [1:0]  rs;
  logic [1:0]  rt;
  logic [1:0]  rd;
  logic [1:0]  writeAddr;
  logic        writeEn;
  logic        halted;

  function automatic logic [15:0] romWord(input logic [3:0] idx);
    case (idx)
      4'd0:    romWord = 16'h710F;
      4'd1:    romWord = 16'h7207;
      4'd2:    romWord = 16'h26C0;
      4'd3:    romWord = 16'h1780;
      4'd4:    romWord = 16'h3B80;
      4'd5:    romWord = 16'h0BC0;
      4'd6:    romWord = 16'h4B40;
      4'd7:    romWord = 16'h6E40;
      4'd8:    romWord = 16'h6B40;
      default: romWord = 16'hFFFF;
    endcase
  endfunction

  assign instr  = romWord(pcReg[4:1]);
  assign opcode = instr[15:12];
  assign rs     = instr[11:10];
  assign rt     = instr[9:8];
  assign rd     = instr[7:6];
  assign immExt = {{8{instr[7]}}, instr[7:0]};
  assign halted = (instr == 16'hFFFF);

  // Register 0 is hardwired to zero on the read side; writes to it are dropped.
  assign rsVal = (rs == 2'd0) ? 16'd0 : regFile[rs];
  assign rtVal = (rt == 2'd0) ? 16'd0 : regFile[rt];

  // PC only walks the 16 ROM words, so it wraps from 30 back to 0.
  assign nextPc = {11'd0, pcReg[4:1] + 4'd1, 1'b0};

  always_comb begin
    aluResult = rsVal + rtVal;
    writeEn   = 1'b0;
    writeAddr = rd;
    case (opcode)
      4'h0: begin aluResult = rsVal + rtVal;    writeEn = 1'b1; end
      4'h1: begin aluResult = rsVal - rtVal;    writeEn = 1'b1; end
      4'h2: begin aluResult = rsVal & rtVal;    writeEn = 1'b1; end
      4'h3: begin aluResult = rsVal | rtVal;    writeEn = 1'b1; end
      4'h4: begin aluResult = ~(rsVal | rtVal); writeEn = 1'b1; end
      4'h6: begin
        aluResult = {15'd0, ($signed(rsVal) < $signed(rtVal))};
        writeEn   = 1'b1;
      end
      4'h7: begin
        aluResult = rsVal + immExt;
        writeEn   = 1'b1;
        writeAddr = rt;
      end
      4'hF: begin
        if (halted) begin
          aluResult = rsVal | rtVal;
        end
      end
      default: begin
        aluResult = rsVal + rtVal;
      end
    endcase
  end

  // Reset wins over everything; a halt word freezes PC and registers.
  always_ff @(negedge clock) begin
    if (reset) begin
      pcReg <= 16'd0;
      for (int i = 0; i < 4; i++) begin
        regFile[i] <= 16'd0;
      end
    end else if (!halted) begin
      pcReg <= nextPc;
      if (writeEn && (writeAddr != 2'd0)) begin
        regFile[writeAddr] <= aluResult;
      end
    end
  end

  assign bus.PC     = pcReg;
  assign bus.IR     = instr;
  assign bus.ALUOut = aluResult;

endmodule

// File: tb/tb_cpu.sv
// Bench for the cpu core: directed program trace plus randomized instruction
// streams compared against a behavioural model of the instruction set.
module tb_cpu;

  logic clock;
  logic reset;

  cpu_if bus ();

  cpu dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  int          assertCount = 0;
  int          failCount   = 0;
  int          modelPc;
  logic [15:0] modelRegs [4];
  logic [15:0] romModel  [16];
  logic        overrideOn;
  logic [15:0] overrideVal;

  logic [15:0] pcTable  [9];
  logic [15:0] aluTable [9];

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] modelIr();
    return overrideOn ? overrideVal : romModel[modelPc / 2];
  endfunction

  // Instruction semantics in plain integer arithmetic, truncated to 16 bits.
  function automatic logic [15:0] modelAlu(input logic [15:0] ir);
    int a, b, sa, sb, imm, r, op;
    op  = int'(ir[15:12]);
    a   = int'(modelRegs[ir[11:10]]);
    b   = int'(modelRegs[ir[9:8]]);
    imm = int'(ir[7:0]);
    if (imm >= 128) imm -= 256;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a & b;
      3:       r = a | b;
      4:       r = ~(a | b);
      6:       r = (sa < sb) ? 1 : 0;
      7:       r = a + imm;
      default: r = (ir == 16'hFFFF) ? (a | b) : (a + b);
    endcase
    return r[15:0];
  endfunction

  function automatic void modelStep(input logic r, input logic [15:0] ir);
    int op, dest;
    logic [15:0] res;
    if (r) begin
      modelPc = 0;
      for (int i = 0; i < 4; i++) modelRegs[i] = 16'd0;
    end else if (ir != 16'hFFFF) begin
      op   = int'(ir[15:12]);
      dest = -1;
      res  = modelAlu(ir);
      if (op <= 4 || op == 6) dest = int'(ir[7:6]);
      else if (op == 7)       dest = int'(ir[9:8]);
      if (dest > 0) modelRegs[dest] = res;
      modelPc = (modelPc + 2) % 32;
    end
  endfunction

  // Drives reset and optionally overrides the ROM word seen by the core.
  task automatic applyStimulus(input logic r, input logic useOverride,
                               input logic [15:0] val);
    reset       = r;
    overrideVal = val;
    if (useOverride) begin
      force dut.instr = overrideVal;
    end else if (overrideOn) begin
      release dut.instr;
    end
    overrideOn = useOverride;
    #1;
  endtask

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, "Pc"},  bus.PC,     modelPc[15:0]);
    checkOutput({tag, "Ir"},  bus.IR,     modelIr());
    checkOutput({tag, "Alu"}, bus.ALUOut, modelAlu(modelIr()));
  endtask

  task automatic advance();
    modelStep(reset, modelIr());
    @(posedge clock);
    #1;
  endtask

  task automatic cycle(input logic r, input logic useOverride,
                       input logic [15:0] val, input string tag);
    applyStimulus(r, useOverride, val);
    checkAgainstModel(tag);
    advance();
  endtask

  task automatic runDefaultTrace(input string tag);
    for (int i = 0; i < 9; i++) begin
      checkOutput({tag, "Pc"},  bus.PC,     pcTable[i]);
      checkOutput({tag, "Alu"}, bus.ALUOut, aluTable[i]);
      cycle(1'b0, 1'b0, 16'h0000, tag);
    end
    checkOutput({tag, "HaltPc"},  bus.PC,     16'd18);
    checkOutput({tag, "HaltIr"},  bus.IR,     16'hFFFF);
    checkOutput({tag, "HaltAlu"}, bus.ALUOut, 16'd22);
  endtask

  initial begin
    logic        rr;
    logic        uo;
    logic [15:0] vv;

    romModel = '{16'h710F, 16'h7207, 16'h26C0, 16'h1780, 16'h3B80, 16'h0BC0,
                 16'h4B40, 16'h6E40, 16'h6B40, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    pcTable  = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd8, 16'd10, 16'd12, 16'd14, 16'd16};
    aluTable = '{16'd15, 16'd7, 16'd7, 16'd8, 16'd15, 16'd22, 16'hFFE0, 16'd0, 16'd1};
    overrideOn  = 1'b0;
    overrideVal = 16'h0000;
    modelPc     = 0;
    for (int i = 0; i < 4; i++) modelRegs[i] = 16'd0;

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    checkOutput("resetPc",  bus.PC,     16'd0);
    checkOutput("resetIr",  bus.IR,     16'h710F);
    checkOutput("resetAlu", bus.ALUOut, 16'd15);

    runDefaultTrace("trace");

    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 16'h0000, "hold");
    checkOutput("holdPc",  bus.PC,     16'd18);
    checkOutput("holdIr",  bus.IR,     16'hFFFF);
    checkOutput("holdAlu", bus.ALUOut, 16'd22);
    checkOutput("holdR1",  dut.regFile[1], 16'd1);
    checkOutput("holdR2",  dut.regFile[2], 16'd15);
    checkOutput("holdR3",  dut.regFile[3], 16'd22);

    cycle(1'b1, 1'b0, 16'h0000, "haltReset");
    checkOutput("haltResetPc",  bus.PC,     16'd0);
    checkOutput("haltResetIr",  bus.IR,     16'h710F);
    checkOutput("haltResetAlu", bus.ALUOut, 16'd15);
    runDefaultTrace("rerun");

    cycle(1'b1, 1'b0, 16'h0000, "midPrep");
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 16'h0000, "mid");
    checkOutput("midPc", bus.PC, 16'd10);
    cycle(1'b1, 1'b0, 16'h0000, "midReset");
    checkOutput("midResetPc",  bus.PC,         16'd0);
    checkOutput("midResetR2",  dut.regFile[2], 16'd0);
    checkOutput("midResetAlu", bus.ALUOut,     16'd15);

    cycle(1'b1, 1'b0, 16'h0000, "r0Prep");
    applyStimulus(1'b0, 1'b1, 16'h700F);
    checkOutput("r0WriteAlu", bus.ALUOut, 16'd15);
    advance();
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checkOutput("r0ReadAlu", bus.ALUOut, 16'd0);
    advance();

    cycle(1'b1, 1'b0, 16'h0000, "sltPrep");
    applyStimulus(1'b0, 1'b1, 16'h71FF);
    checkOutput("sltLoadAlu", bus.ALUOut, 16'hFFFF);
    advance();
    applyStimulus(1'b0, 1'b1, 16'h6440);
    checkOutput("sltSignedAlu", bus.ALUOut, 16'd1);
    advance();

    cycle(1'b1, 1'b0, 16'h0000, "randPrep");
    for (int n = 0; n < 300; n++) begin
      rr = ($urandom_range(0, 24) == 0);
      uo = ($urandom_range(0, 3) != 0);
      vv = 16'($urandom);
      if ($urandom_range(0, 9) == 0) vv = 16'hFFFF;
      cycle(rr, uo, vv, "rand");
    end
    applyStimulus(1'b0, 1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
